// File: rtl/intersection_sequencer.sv
// Purpose: phase sequencer for a four-way intersection; drives the 4-bit phase code and a phase-entry pulse.
// Latency: inputs affect fsmOut/phaseStart on the next rising clk edge; every output comes straight from a flop.
// Backpressure: none; tick is a free-running timebase and the light decoder always accepts the current code.
module intersection_sequencer #(
    parameter int RED_T   = 2,
    parameter int LEFT_T  = 5,
    parameter int LEFTY_T = 2,
    parameter int GREEN_T = 10,
    parameter int YEL_T   = 3,
    parameter int TW      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       nsLeftReq,
    input  logic       ewLeftReq,
    input  logic       emergency,
    output logic [3:0] fsmOut,
    output logic       phaseStart
);

    typedef enum logic [3:0] {
        ALL_RED_A  = 4'd0,
        NS_LEFT    = 4'd1,
        NS_LEFT_Y  = 4'd2,
        NS_GREEN   = 4'd3,
        NS_YELLOW  = 4'd4,
        ALL_RED_B  = 4'd5,
        EW_LEFT    = 4'd6,
        EW_LEFT_Y  = 4'd7,
        EW_GREEN   = 4'd8,
        EW_YELLOW  = 4'd9,
        EMERG_HOLD = 4'd15
    } state_t;

    // Timer reload values are stored as DUR-1 so a phase lasts exactly DUR ticks.
    localparam logic [TW-1:0] RED_D   = TW'(RED_T - 1);
    localparam logic [TW-1:0] LEFT_D  = TW'(LEFT_T - 1);
    localparam logic [TW-1:0] LEFTY_D = TW'(LEFTY_T - 1);
    localparam logic [TW-1:0] GREEN_D = TW'(GREEN_T - 1);
    localparam logic [TW-1:0] YEL_D   = TW'(YEL_T - 1);
    localparam logic [TW-1:0] ONE     = TW'(1);

    state_t          r_state;
    logic [TW-1:0]   r_timer;
    logic            r_phase_start;
    logic            r_ns_pend;
    logic            r_ew_pend;

    state_t          w_next_state;
    logic            w_expire;
    logic            w_change;

    // Reload value for the phase being entered; the emergency hold is untimed.
    function automatic logic [TW-1:0] f_dur(input state_t s);
        case (s)
            ALL_RED_A, ALL_RED_B:   f_dur = RED_D;
            NS_LEFT, EW_LEFT:       f_dur = LEFT_D;
            NS_LEFT_Y, EW_LEFT_Y:   f_dur = LEFTY_D;
            NS_GREEN, EW_GREEN:     f_dur = GREEN_D;
            NS_YELLOW, EW_YELLOW:   f_dur = YEL_D;
            default:                f_dur = '0;
        endcase
    endfunction

    // Next-phase decision: expiry on tick, emergency cuts left/green phases short, illegal codes recover.
    always_comb begin
        w_expire     = tick && (r_timer == '0);
        w_next_state = r_state;
        case (r_state)
            ALL_RED_A: begin
                if (w_expire) begin
                    if (emergency)      w_next_state = EMERG_HOLD;
                    else if (r_ns_pend) w_next_state = NS_LEFT;
                    else                w_next_state = NS_GREEN;
                end
            end
            NS_LEFT:   if (emergency || w_expire) w_next_state = NS_LEFT_Y;
            NS_LEFT_Y: if (w_expire)              w_next_state = NS_GREEN;
            NS_GREEN:  if (emergency || w_expire) w_next_state = NS_YELLOW;
            NS_YELLOW: if (w_expire)              w_next_state = ALL_RED_B;
            ALL_RED_B: begin
                if (w_expire) begin
                    if (emergency)      w_next_state = EMERG_HOLD;
                    else if (r_ew_pend) w_next_state = EW_LEFT;
                    else                w_next_state = EW_GREEN;
                end
            end
            EW_LEFT:    if (emergency || w_expire) w_next_state = EW_LEFT_Y;
            EW_LEFT_Y:  if (w_expire)              w_next_state = EW_GREEN;
            EW_GREEN:   if (emergency || w_expire) w_next_state = EW_YELLOW;
            EW_YELLOW:  if (w_expire)              w_next_state = ALL_RED_A;
            EMERG_HOLD: if (!emergency)            w_next_state = ALL_RED_A;
            default:                               w_next_state = ALL_RED_A;
        endcase
        w_change = (w_next_state != r_state);
    end

    // Phase register, timer, entry pulse and left-turn demand latches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ALL_RED_A;
            r_timer       <= RED_D;
            r_phase_start <= 1'b0;
            r_ns_pend     <= 1'b0;
            r_ew_pend     <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_phase_start <= w_change;
            if (w_change) begin
                r_timer <= f_dur(w_next_state);
            end else if (tick && (r_state != EMERG_HOLD) && (r_timer != '0)) begin
                r_timer <= r_timer - ONE;
            end
            // Entering the left phase consumes the demand, even if the sensor is still active.
            if ((w_next_state == NS_LEFT) && (r_state != NS_LEFT)) r_ns_pend <= 1'b0;
            else                                                   r_ns_pend <= r_ns_pend | nsLeftReq;
            if ((w_next_state == EW_LEFT) && (r_state != EW_LEFT)) r_ew_pend <= 1'b0;
            else                                                   r_ew_pend <= r_ew_pend | ewLeftReq;
        end
    end

    assign fsmOut     = r_state;
    assign phaseStart = r_phase_start;

endmodule

// File: tb/tb_intersection_sequencer.sv
// Purpose: self-checking bench for intersection_sequencer: directed phase table, corner sequences, random run vs model.
// Latency: outputs are compared on the falling edge, half a clk after the edge that produced them.
// Backpressure: none; the bench drives tick, sensors, emergency and reset freely.
module tb_intersection_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       nsLeftReq;
    logic       ewLeftReq;
    logic       emergency;
    logic [3:0] fsmOut;
    logic       phaseStart;

    intersection_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .nsLeftReq  (nsLeftReq),
        .ewLeftReq  (ewLeftReq),
        .emergency  (emergency),
        .fsmOut     (fsmOut),
        .phaseStart (phaseStart)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase durations in ticks, indexed by phase code 0..9.
    int dur [10] = '{2, 5, 2, 10, 3, 2, 5, 2, 10, 3};
    int m_code;
    int m_left;     // ticks still to be served in the current phase
    int m_ps;
    bit m_nsp;
    bit m_ewp;
    bit chk_en = 1'b0;

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_code = 0; m_left = dur[0]; m_ps = 0; m_nsp = 1'b0; m_ewp = 1'b0;
        end else begin
            int nc;
            bit go_grn;
            nc = m_code;
            go_grn = (m_code == 1) || (m_code == 3) || (m_code == 6) || (m_code == 8);
            if (m_code == 15) begin
                if (!emergency) nc = 0;
            end else if (m_code > 9) begin
                nc = 0;
            end else if (go_grn && emergency) begin
                nc = m_code + 1;
            end else if (tick) begin
                if (m_left == 1) begin
                    case (m_code)
                        0:       nc = emergency ? 15 : (m_nsp ? 1 : 3);
                        5:       nc = emergency ? 15 : (m_ewp ? 6 : 8);
                        9:       nc = 0;
                        default: nc = m_code + 1;
                    endcase
                end else begin
                    m_left = m_left - 1;
                end
            end
            m_ps = (nc != m_code) ? 1 : 0;
            if (nc == 1 && m_code != 1) m_nsp = 1'b0; else if (nsLeftReq) m_nsp = 1'b1;
            if (nc == 6 && m_code != 6) m_ewp = 1'b0; else if (ewLeftReq) m_ewp = 1'b1;
            if (nc != m_code) begin
                m_code = nc;
                m_left = (nc == 15) ? 0 : dur[nc];
            end
        end
    end

    // Continuous comparison against the model on every falling edge.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("model_fsmOut", int'(fsmOut), m_code);
            check("model_phaseStart", int'(phaseStart), m_ps);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clk1();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Each tick period is 4 clks with tick high on the first; counts phaseStart pulses seen.
    task automatic run_ticks(input int n, output int ps);
        ps = 0;
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            clk1();
            ps += int'(phaseStart);
            tick = 1'b0;
            repeat (3) begin
                clk1();
                ps += int'(phaseStart);
            end
        end
    endtask

    typedef struct {
        logic       ns;
        logic       ew;
        logic       em;
        int         n;
        logic [3:0] code;
        int         ps;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic ns, input logic ew, input logic em, input int n,
                       input logic [3:0] code, input int ps);
        vec_t v;
        v.ns = ns; v.ew = ew; v.em = em; v.n = n; v.code = code; v.ps = ps;
        vt.push_back(v);
    endtask

    initial begin
        int ps;
        int chg;

        // Default cycle: 0(2) 3(10) 4(3) 5(2) 8(10) 9(3) = 30 ticks, 6 entries.
        add(0,0,0, 1, 4'd0, 0); add(0,0,0, 1, 4'd3, 1); add(0,0,0, 9, 4'd3, 0);
        add(0,0,0, 1, 4'd4, 1); add(0,0,0, 3, 4'd5, 1); add(0,0,0, 2, 4'd8, 1);
        add(0,0,0,10, 4'd9, 1); add(0,0,0, 3, 4'd0, 1);
        // N/S left request during EW_GREEN, served next cycle.
        add(0,0,0,17, 4'd8, 4); add(1,0,0, 1, 4'd8, 0); add(0,0,0,12, 4'd0, 2);
        add(0,0,0, 2, 4'd1, 1); add(0,0,0, 5, 4'd2, 1); add(0,0,0, 2, 4'd3, 1);
        add(0,0,0,10, 4'd4, 1); add(0,0,0, 3, 4'd5, 1); add(0,0,0, 2, 4'd8, 1);
        add(0,0,0,10, 4'd9, 1); add(0,0,0, 3, 4'd0, 1);
        // Demand consumed: the following cycle skips the left phase.
        add(0,0,0, 2, 4'd3, 1); add(0,0,0,28, 4'd0, 5);
        // Both requests held: full 44-tick cycle.
        add(1,1,0, 2, 4'd1, 1); add(1,1,0, 5, 4'd2, 1); add(1,1,0, 2, 4'd3, 1);
        add(1,1,0,10, 4'd4, 1); add(1,1,0, 3, 4'd5, 1); add(1,1,0, 2, 4'd6, 1);
        add(1,1,0, 5, 4'd7, 1); add(1,1,0, 2, 4'd8, 1); add(1,1,0,10, 4'd9, 1);
        add(1,1,0, 3, 4'd0, 1);
        // Requests dropped: latches re-set after their clear, so both lefts run once more.
        add(0,0,0, 2, 4'd1, 1); add(0,0,0, 5, 4'd2, 1); add(0,0,0, 2, 4'd3, 1);
        add(0,0,0,10, 4'd4, 1); add(0,0,0, 3, 4'd5, 1); add(0,0,0, 2, 4'd6, 1);
        add(0,0,0, 5, 4'd7, 1); add(0,0,0, 2, 4'd8, 1);

        reset = 1'b1; tick = 1'b0; nsLeftReq = 1'b0; ewLeftReq = 1'b0; emergency = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_fsmOut", int'(fsmOut), 0);
        check("reset_phaseStart", int'(phaseStart), 0);
        reset = 1'b0;
        clk1();
        check("release_fsmOut", int'(fsmOut), 0);
        check("release_no_pulse", int'(phaseStart), 0);

        foreach (vt[i]) begin
            nsLeftReq = vt[i].ns; ewLeftReq = vt[i].ew; emergency = vt[i].em;
            run_ticks(vt[i].n, ps);
            check($sformatf("row%0d_code", i), int'(fsmOut), int'(vt[i].code));
            check($sformatf("row%0d_pulses", i), ps, vt[i].ps);
        end
        nsLeftReq = 1'b0; ewLeftReq = 1'b0;

        // tick held low in EW_GREEN: nothing moves; emergency still cuts to yellow in one clk.
        chg = 0;
        repeat (100) begin
            clk1();
            if (fsmOut != 4'd8 || phaseStart != 1'b0) chg++;
        end
        check("tickhold_stable", chg, 0);
        emergency = 1'b1;
        clk1();
        check("em_ew_yellow", int'(fsmOut), 9);
        check("em_ew_yellow_pulse", int'(phaseStart), 1);
        emergency = 1'b0;
        run_ticks(3, ps); check("ew_yellow_full", int'(fsmOut), 0);
        run_ticks(2, ps); check("to_ns_green", int'(fsmOut), 3);

        // Emergency at NS_GREEN tick 4: yellow, all-red B, then hold.
        run_ticks(4, ps); check("ns_green_t4", int'(fsmOut), 3);
        emergency = 1'b1;
        clk1();
        check("em_ns_yellow", int'(fsmOut), 4);
        run_ticks(2, ps); check("em_yellow_not_short", int'(fsmOut), 4);
        run_ticks(1, ps); check("em_red_b", int'(fsmOut), 5);
        run_ticks(2, ps); check("em_hold", int'(fsmOut), 15);
        run_ticks(5, ps); check("em_hold_ticks", int'(fsmOut), 15);
        check("em_hold_no_pulse", ps, 0);
        emergency = 1'b0;
        clk1();
        check("em_exit_red_a", int'(fsmOut), 0);
        check("em_exit_pulse", int'(phaseStart), 1);
        run_ticks(1, ps); check("em_exit_clear_t1", int'(fsmOut), 0);
        run_ticks(1, ps); check("em_exit_clear_t2", int'(fsmOut), 3);

        // Asynchronous reset mid NS_YELLOW with demand pending.
        run_ticks(10, ps); check("pre_reset_yellow", int'(fsmOut), 4);
        nsLeftReq = 1'b1; ewLeftReq = 1'b1;
        clk1();
        nsLeftReq = 1'b0; ewLeftReq = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async_reset_fsmOut", int'(fsmOut), 0);
        check("async_reset_phaseStart", int'(phaseStart), 0);
        clk1();
        reset = 1'b0;
        run_ticks(2, ps);  check("post_reset_no_nsleft", int'(fsmOut), 3);
        run_ticks(15, ps); check("post_reset_no_ewleft", int'(fsmOut), 8);

        // Random traffic checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 999) == 0) reset = 1'b1;
            tick      = (!tick) && ($urandom_range(0, 2) == 0);
            nsLeftReq = ($urandom_range(0, 19) == 0);
            ewLeftReq = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 149) == 0) emergency = ~emergency;
        end
        @(negedge clk);
        #1;
        reset = 1'b0; tick = 1'b0; emergency = 1'b0; nsLeftReq = 1'b0; ewLeftReq = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/intersection_sequencer.md
Name: intersection_sequencer

Overview:
- Timing and sequencing controller for the four-way intersection.
- Steps through the signal phases and drives the 4-bit phase code consumed by the light-decode block, which maps the code to green/yellow/red/left outputs for N, S, E and W.
- Durations are counted in external ticks.
- Left-turn phases run only when demand has been latched.
- An emergency input forces a safe all-red hold.

Parameters:
- RED_T, 2, all-red clearance duration in ticks (min 1)
- LEFT_T, 5, protected-left duration in ticks (min 1)
- LEFTY_T, 2, left-turn yellow duration in ticks (min 1)
- GREEN_T, 10, through-green duration in ticks (min 1)
- YEL_T, 3, through-yellow duration in ticks (min 1)
- TW, 8, timer width; every duration must be at most 2^TW.

Ports:
- clk  input  1  system clock; everything is sampled on the rising edge
- reset  input  1  asynchronous, active-high reset
- tick  input  1  one-clk-wide timebase pulse
- nsLeftReq  input  1  N/S left-turn sensor, level
- ewLeftReq  input  1  E/W left-turn sensor, level
- emergency  input  1  emergency pre-emption request, level
- fsmOut  output  4  phase code to the light decoder
- phaseStart  output  1  one-clk pulse on phase entry

Behaviour:
- Phase codes:
  - 0 ALL_RED_A, 1 NS_LEFT, 2 NS_LEFT_Y, 3 NS_GREEN, 4 NS_YELLOW
  - 5 ALL_RED_B, 6 EW_LEFT, 7 EW_LEFT_Y, 8 EW_GREEN, 9 EW_YELLOW
  - 15 EMERG_HOLD (all red)
  - Codes 10-14 are never driven; if the state register holds one, the next clk goes to ALL_RED_A.
- Reset, asynchronous:
  - fsmOut=0, timer=RED_T-1, phaseStart=0, both pending latches=0.
  - Reset may assert mid-phase; the sequence restarts at ALL_RED_A.
- Timer:
  - On entry to any timed phase, timer loads DUR-1 for that phase.
  - On a clk with tick=1: if timer==0 the phase expires and the next phase is visible on the following edge; otherwise timer decrements.
  - With tick aligned, each phase therefore lasts exactly DUR ticks.
  - tick=0 means the timer holds.
- Expiry transitions:
  - ALL_RED_A -> NS_LEFT if nsLeftPend, else NS_GREEN
  - NS_LEFT -> NS_LEFT_Y -> NS_GREEN -> NS_YELLOW -> ALL_RED_B
  - ALL_RED_B -> EW_LEFT if ewLeftPend, else EW_GREEN
  - EW_LEFT -> EW_LEFT_Y -> EW_GREEN -> EW_YELLOW -> ALL_RED_A
  - The ALL_RED_A/ALL_RED_B branch decision uses the pending latch value in the expiry cycle.
- Pending latches:
  - nsLeftPend is set on any clk with nsLeftReq=1 and cleared on the edge that enters NS_LEFT. Clear wins if req=1 on that same edge.
  - ewLeftPend behaves identically for ewLeftReq and EW_LEFT.
  - Both latches keep updating in every phase, including EMERG_HOLD.
- Emergency, sampled every clk and independent of tick:
  - In NS_LEFT, NS_GREEN, EW_LEFT or EW_GREEN: the next edge forces the matching yellow (NS_LEFT_Y, NS_YELLOW, EW_LEFT_Y, EW_YELLOW) and the timer loads that yellow's DUR-1.
  - Yellow phases are never shortened; they run to expiry, then go to the normal all-red.
  - ALL_RED_A or ALL_RED_B expiring with emergency=1 goes to EMERG_HOLD instead of the normal next phase.
  - In EMERG_HOLD, tick is ignored. The state holds while emergency=1; the first clk with emergency=0 goes to ALL_RED_A with timer=RED_T-1, so full clearance precedes N/S service.
  - If emergency and expiry coincide in a left/green phase, the result is the same (enter yellow).
- phaseStart:
  - Registered; high for exactly one clk, the first clk a new code is on fsmOut.
  - Not pulsed on reset release.
  - Stays 0 while a state holds.
- Safety invariant: NS and EW are never simultaneously in a non-red phase, and every change of right-of-way passes through ALL_RED_A, ALL_RED_B or EMERG_HOLD.
- No combinational path from inputs to outputs; fsmOut and phaseStart come directly from flops.

Test Plan:
- Tick every 4 clks, no requests, defaults, release reset -> fsmOut 0 for 2 ticks, 3 for 10, 4 for 3, 5 for 2, 8 for 10, 9 for 3, back to 0; period 30 ticks; phaseStart pulses 6 times per cycle.
- Pulse nsLeftReq 1 clk during EW_GREEN -> next cycle runs 0, 1 (5 ticks), 2 (2 ticks), 3; nsLeftPend cleared on entry to 1; the following cycle skips phase 1.
- Both reqs held high continuously -> cycle 0,1,2,3,4,5,6,7,8,9 = 44 ticks; each latch re-sets right after its clear.
- Emergency asserted at NS_GREEN tick 4 -> next clk fsmOut=4, then 3 ticks, 5 for 2 ticks, then 15; hold 15 with ticks running; deassert -> next clk 0, timer=1.
- Assert reset mid NS_YELLOW with pending set -> fsmOut=0, phaseStart=0, latches=0 immediately, without waiting for a clk edge; after release the normal sequence resumes from phase 0 with no left phases.
- tick held 0 for 100 clks inside GREEN -> fsmOut stable; emergency still forces yellow within 1 clk.
